// File: rtl/ticket_vending_fsm_p_if.sv
// Front-panel / dispenser bus for the parametrised ticket vending controller.
// The master drives requests and coins; the slave is the controller.
interface ticket_vending_fsm_p_if #(
  parameter int unsigned N_STATIONS  = 5,
  parameter int unsigned MAX_TICKETS = 5,
  parameter int unsigned MONEY_W     = 6,
  parameter int unsigned TOTAL_W     = 8
);
  localparam int unsigned ID_W  = $clog2(N_STATIONS + 1);
  localparam int unsigned CNT_W = $clog2(MAX_TICKETS + 1);

  logic               req_valid;
  logic [ID_W-1:0]    origin;
  logic [ID_W-1:0]    destination;
  logic [CNT_W-1:0]   how_many_ticket;
  logic               coin_valid;
  logic [MONEY_W-1:0] money;
  logic               cancel;

  logic               req_ready;
  logic               coin_ready;
  logic [TOTAL_W-1:0] cost_of_ticket;
  logic [TOTAL_W-1:0] money_to_pay;
  logic [TOTAL_W-1:0] total_money;
  logic [TOTAL_W-1:0] change;
  logic [CNT_W-1:0]   tickets_out;
  logic               done;
  logic               refund;
  logic               err;

  modport master (
    output req_valid, origin, destination, how_many_ticket, coin_valid, money, cancel,
    input  req_ready, coin_ready, cost_of_ticket, money_to_pay, total_money, change,
           tickets_out, done, refund, err
  );

  modport slave (
    input  req_valid, origin, destination, how_many_ticket, coin_valid, money, cancel,
    output req_ready, coin_ready, cost_of_ticket, money_to_pay, total_money, change,
           tickets_out, done, refund, err
  );
endinterface

// File: rtl/ticket_vending_fsm_p.sv
// Ticket vending controller: quote fare, collect coins, settle with change or refund.
// Optional idle-coin timeout enabled by defining TVM_TIMEOUT_EN.
module ticket_vending_fsm_p #(
  parameter int unsigned N_STATIONS     = 5,
  parameter int unsigned FARE_UNIT      = 5,
  parameter int unsigned MAX_TICKETS    = 5,
  parameter int unsigned MONEY_W        = 6,
  parameter int unsigned TOTAL_W        = 8,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  ticket_vending_fsm_p_if.slave bus
);
  localparam int unsigned ID_W  = $clog2(N_STATIONS + 1);
  localparam int unsigned CNT_W = $clog2(MAX_TICKETS + 1);

  typedef enum logic [1:0] {IDLE, QUOTE, COLLECT, SETTLE} state_t;

  state_t             state_q, state_d;
  logic [TOTAL_W-1:0] cost_q, cost_d;
  logic [TOTAL_W-1:0] pay_q, pay_d;
  logic [TOTAL_W-1:0] total_q, total_d;
  logic [TOTAL_W-1:0] change_q, change_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   tickets_q, tickets_d;
  logic               req_ready_q, req_ready_d;
  logic               coin_ready_q, coin_ready_d;
  logic               done_q, done_d;
  logic               refund_q, refund_d;
  logic               err_q, err_d;

  logic               req_ok_c;
  logic [ID_W-1:0]    span_c;
  logic [TOTAL_W-1:0] cost_c;
  logic [TOTAL_W:0]   sum_c;
  logic [TOTAL_W-1:0] total_add_c;
  logic [TOTAL_W-1:0] total_c;
  logic               timeout_c;

  // Request validation and single-ticket fare (span counts both end stations)
  always_comb begin
    req_ok_c = (bus.origin != '0) && (bus.origin <= ID_W'(N_STATIONS)) &&
               (bus.destination != '0) && (bus.destination <= ID_W'(N_STATIONS)) &&
               (bus.how_many_ticket != '0) && (bus.how_many_ticket <= CNT_W'(MAX_TICKETS));
    if (bus.destination >= bus.origin) span_c = bus.destination - bus.origin + ID_W'(1);
    else                               span_c = bus.origin - bus.destination + ID_W'(1);
    cost_c = TOTAL_W'(span_c) * TOTAL_W'(FARE_UNIT);
  end

  // Saturating coin accumulation
  always_comb begin
    sum_c       = {1'b0, total_q} + (TOTAL_W + 1)'(bus.money);
    total_add_c = sum_c[TOTAL_W] ? '1 : sum_c[TOTAL_W-1:0];
  end

`ifdef TVM_TIMEOUT_EN
  localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TO_W-1:0] idle_cnt_q, idle_cnt_d;

  // Counts consecutive coin-less COLLECT cycles; restarts on entry and on every coin
  always_comb begin
    idle_cnt_d = idle_cnt_q;
    timeout_c  = 1'b0;
    if (state_q == QUOTE) begin
      idle_cnt_d = '0;
    end else if (state_q == COLLECT) begin
      if (bus.coin_valid)                                 idle_cnt_d = '0;
      else if (idle_cnt_q == TO_W'(TIMEOUT_CYCLES - 1))   timeout_c  = 1'b1;
      else                                                idle_cnt_d = idle_cnt_q + TO_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) idle_cnt_q <= '0;
    else        idle_cnt_q <= idle_cnt_d;
  end
`else
  assign timeout_c = 1'b0;
`endif

  // Next state and next registered outputs
  always_comb begin
    state_d   = state_q;
    cost_d    = cost_q;
    pay_d     = pay_q;
    total_d   = total_q;
    change_d  = change_q;
    count_d   = count_q;
    tickets_d = tickets_q;
    done_d    = 1'b0;
    refund_d  = 1'b0;
    err_d     = 1'b0;
    total_c   = bus.coin_valid ? total_add_c : total_q;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          if (req_ok_c) begin
            cost_d    = cost_c;
            count_d   = bus.how_many_ticket;
            change_d  = '0;
            tickets_d = '0;
            state_d   = QUOTE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      QUOTE: begin
        pay_d   = cost_q * TOTAL_W'(count_q);
        state_d = COLLECT;
      end
      COLLECT: begin
        total_d = total_c;
        // Cancel or timeout wins over a coin that would complete payment
        if (bus.cancel || timeout_c) begin
          change_d  = total_c;
          tickets_d = '0;
          refund_d  = 1'b1;
          done_d    = 1'b1;
          state_d   = SETTLE;
        end else if (total_c >= pay_q) begin
          change_d  = total_c - pay_q;
          tickets_d = count_q;
          done_d    = 1'b1;
          state_d   = SETTLE;
        end
      end
      SETTLE: begin
        cost_d  = '0;
        pay_d   = '0;
        total_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    req_ready_d  = (state_d == IDLE);
    coin_ready_d = (state_d == COLLECT);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      cost_q       <= '0;
      pay_q        <= '0;
      total_q      <= '0;
      change_q     <= '0;
      count_q      <= '0;
      tickets_q    <= '0;
      req_ready_q  <= 1'b0;
      coin_ready_q <= 1'b0;
      done_q       <= 1'b0;
      refund_q     <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cost_q       <= cost_d;
      pay_q        <= pay_d;
      total_q      <= total_d;
      change_q     <= change_d;
      count_q      <= count_d;
      tickets_q    <= tickets_d;
      req_ready_q  <= req_ready_d;
      coin_ready_q <= coin_ready_d;
      done_q       <= done_d;
      refund_q     <= refund_d;
      err_q        <= err_d;
    end
  end

  assign bus.req_ready      = req_ready_q;
  assign bus.coin_ready     = coin_ready_q;
  assign bus.cost_of_ticket = cost_q;
  assign bus.money_to_pay   = pay_q;
  assign bus.total_money    = total_q;
  assign bus.change         = change_q;
  assign bus.tickets_out    = tickets_q;
  assign bus.done           = done_q;
  assign bus.refund         = refund_q;
  assign bus.err            = err_q;
endmodule

// File: tb/tb_ticket_vending_fsm_p.sv
// Self-checking bench for ticket_vending_fsm_p: vector table plus hand sequences.
module tb_ticket_vending_fsm_p;
  localparam int unsigned N_STATIONS     = 5;
  localparam int unsigned FARE_UNIT      = 5;
  localparam int unsigned MAX_TICKETS    = 5;
  localparam int unsigned MONEY_W        = 6;
  localparam int unsigned TOTAL_W        = 8;
  localparam int unsigned TIMEOUT_CYCLES = 16;
  localparam int unsigned ID_W           = $clog2(N_STATIONS + 1);
  localparam int unsigned CNT_W          = $clog2(MAX_TICKETS + 1);
  localparam int          NVEC           = 8;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  ticket_vending_fsm_p_if #(
    .N_STATIONS(N_STATIONS), .MAX_TICKETS(MAX_TICKETS), .MONEY_W(MONEY_W), .TOTAL_W(TOTAL_W)
  ) bus ();

  ticket_vending_fsm_p #(
    .N_STATIONS(N_STATIONS), .FARE_UNIT(FARE_UNIT), .MAX_TICKETS(MAX_TICKETS),
    .MONEY_W(MONEY_W), .TOTAL_W(TOTAL_W), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int o; int d; int n;
    int c[4]; int nc; int cancel_at;
    bit err; int cost; int pay; int change; int tix; bit refund;
  } vec_t;

  typedef struct {
    bit err; int cost; int pay; int change; int tix; bit refund;
  } exp_t;

  vec_t vecs[NVEC];
  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    else             passed++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input int o, input int d, input int n,
                              input int c0, input int c1, input int c2, input int c3,
                              input int nc, input int cancel_at, input bit err,
                              input int cost, input int pay, input int change,
                              input int tix, input bit refund);
    vec_t v;
    v.o = o; v.d = d; v.n = n;
    v.c[0] = c0; v.c[1] = c1; v.c[2] = c2; v.c[3] = c3;
    v.nc = nc; v.cancel_at = cancel_at;
    v.err = err; v.cost = cost; v.pay = pay; v.change = change; v.tix = tix; v.refund = refund;
    return v;
  endfunction

  task automatic drive_req(input int o, input int d, input int n);
    bus.req_valid       = 1'b1;
    bus.origin          = ID_W'(o);
    bus.destination     = ID_W'(d);
    bus.how_many_ticket = CNT_W'(n);
    tick();
    bus.req_valid       = 1'b0;
  endtask

  task automatic drive_coin(input int c, input bit cxl);
    bus.coin_valid = 1'b1;
    bus.money      = MONEY_W'(c);
    bus.cancel     = cxl;
    tick();
    bus.coin_valid = 1'b0;
    bus.cancel     = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!bus.done && n < budget) begin
      tick();
      n++;
    end
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    exp_t x;
    e.err = v.err; e.cost = v.cost; e.pay = v.pay;
    e.change = v.change; e.tix = v.tix; e.refund = v.refund;
    sb.push_back(e);
    drive_req(v.o, v.d, v.n);
    x = sb.pop_front();
    if (x.err) begin
      chk("err_pulse", 32'(bus.err), 1);
      chk("err_req_ready", 32'(bus.req_ready), 1);
      chk("err_cost_hold", 32'(bus.cost_of_ticket), 0);
      tick();
      chk("err_one_cycle", 32'(bus.err), 0);
      return;
    end
    chk("quote_cost", 32'(bus.cost_of_ticket), x.cost);
    chk("quote_no_err", 32'(bus.err), 0);
    tick();
    chk("collect_pay", 32'(bus.money_to_pay), x.pay);
    chk("collect_coin_ready", 32'(bus.coin_ready), 1);
    for (int i = 0; i < v.nc; i++) drive_coin(v.c[i], i == v.cancel_at);
    wait_done(8);
    chk("settle_done", 32'(bus.done), 1);
    chk("settle_change", 32'(bus.change), x.change);
    chk("settle_tickets", 32'(bus.tickets_out), x.tix);
    chk("settle_refund", 32'(bus.refund), 32'(x.refund));
    tick();
    chk("done_one_cycle", 32'(bus.done), 0);
    chk("idle_req_ready", 32'(bus.req_ready), 1);
    chk("idle_total_clear", 32'(bus.total_money), 0);
    chk("change_hold", 32'(bus.change), x.change);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //           o  d  n  c0  c1  c2  c3 nc cxl err cost pay chg tix ref
    vecs[0] = mk(2, 4, 3, 20, 20, 10,  0, 3, -1, 0,  15,  45,  5, 3, 0);
    vecs[1] = mk(5, 1, 1, 25,  0,  0,  0, 1, -1, 0,  25,  25,  0, 1, 0);
    vecs[2] = mk(0, 3, 1,  0,  0,  0,  0, 0, -1, 1,   0,   0,  0, 0, 0);
    vecs[3] = mk(1, 2, 6,  0,  0,  0,  0, 0, -1, 1,   0,   0,  0, 0, 0);
    vecs[4] = mk(1, 1, 3, 10,  5,  0,  0, 2,  1, 0,   5,  15, 15, 0, 1);
    vecs[5] = mk(3, 3, 1, 63,  0,  0,  0, 1, -1, 0,   5,   5, 58, 1, 0);
    vecs[6] = mk(6, 1, 1,  0,  0,  0,  0, 0, -1, 1,   0,   0,  0, 0, 0);
    vecs[7] = mk(1, 5, 5, 63, 63,  0,  0, 2, -1, 0,  25, 125,  1, 5, 0);

    bus.req_valid = 1'b0; bus.origin = '0; bus.destination = '0; bus.how_many_ticket = '0;
    bus.coin_valid = 1'b0; bus.money = '0; bus.cancel = 1'b0;

    tick();
    tick();
    chk("rst_req_ready", 32'(bus.req_ready), 0);
    chk("rst_coin_ready", 32'(bus.coin_ready), 0);
    chk("rst_cost", 32'(bus.cost_of_ticket), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_change", 32'(bus.change), 0);
    chk("rst_tickets", 32'(bus.tickets_out), 0);
    reset = 1'b1;
    tick();
    chk("rel_req_ready", 32'(bus.req_ready), 1);

    // Coins and cancel while idle must be ignored
    drive_coin(20, 1'b1);
    chk("idle_coin_total", 32'(bus.total_money), 0);
    chk("idle_coin_done", 32'(bus.done), 0);

    for (int i = 0; i < NVEC; i++) run_vec(vecs[i]);

    // Cancel beats a coin that would complete payment
    drive_req(2, 2, 1);
    tick();
    drive_coin(10, 1'b1);
    chk("cxl_beats_refund", 32'(bus.refund), 1);
    chk("cxl_beats_change", 32'(bus.change), 10);
    chk("cxl_beats_tix", 32'(bus.tickets_out), 0);
    tick();

    // Reset in the middle of COLLECT
    drive_req(1, 5, 2);
    tick();
    chk("mid_pay", 32'(bus.money_to_pay), 50);
    drive_coin(20, 1'b0);
    drive_coin(10, 1'b0);
    chk("mid_total", 32'(bus.total_money), 30);
    reset = 1'b0;
    tick();
    chk("mid_rst_total", 32'(bus.total_money), 0);
    chk("mid_rst_pay", 32'(bus.money_to_pay), 0);
    chk("mid_rst_cost", 32'(bus.cost_of_ticket), 0);
    chk("mid_rst_done", 32'(bus.done), 0);
    chk("mid_rst_refund", 32'(bus.refund), 0);
    chk("mid_rst_coin_ready", 32'(bus.coin_ready), 0);
    reset = 1'b1;
    tick();
    chk("mid_rel_req_ready", 32'(bus.req_ready), 1);
    chk("mid_rel_done", 32'(bus.done), 0);

`ifdef TVM_TIMEOUT_EN
    // 16 coin-less cycles in COLLECT refund the collected money
    drive_req(1, 2, 1);
    tick();
    drive_coin(5, 1'b0);
    for (int i = 0; i < 15; i++) tick();
    chk("to_not_yet", 32'(bus.done), 0);
    tick();
    chk("to_done", 32'(bus.done), 1);
    chk("to_refund", 32'(bus.refund), 1);
    chk("to_change", 32'(bus.change), 5);
    tick();

    // A coin at idle cycle 15 restarts the count
    drive_req(1, 2, 1);
    tick();
    drive_coin(5, 1'b0);
    for (int i = 0; i < 14; i++) tick();
    drive_coin(1, 1'b0);
    for (int i = 0; i < 15; i++) tick();
    chk("to_restart_not_yet", 32'(bus.done), 0);
    tick();
    chk("to_restart_done", 32'(bus.done), 1);
    chk("to_restart_change", 32'(bus.change), 6);
    tick();
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
